nano_ctrl_mc: RTL
=================

# nano_ctrl_mc

Parametrised multicycle control unit for the Nano processor, the successor to the fixed 8-bit controller. It sequences fetch, wait, decode, execute and PC-update for the 16-opcode ISA and drives the ULA, register-file and PC-mux selects. Unlike the previous controller, it evaluates all four conditional branches, has a configurable instruction-memory wait, and runs ready/valid handshakes for INPUT and OUTPUT. It sits between instruction memory and the datapath, with one instance per core.

## Interface
- DATA_W, 8: ULA result width.
- IMEM_WAIT, 1: cycles spent in WAIT for the instruction read. Legal range is 1..15.
- SIGNED_BR, 1: 1 = BLT/BGT are signed (sign bit of result_ula); 0 = unsigned (ula_borrow).

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- op  in  4  opcode from the instruction register, valid from DECODE onward
- result_ula  in  DATA_W  ULA result
- ula_borrow  in  1  borrow out of ULA SUB
- in_valid  in  1  input device has data
- out_ready  in  1  output device accepts data
- estado  out  3  current state
- cmd_ula  out  3  0=TSTR1 1=ADD 2=AND 3=OR 4=SUB 5=NEG 6=NOT
- wr  out  1  register-file write enable
- sel_dt_wr  out  2  write-data source: 0=ULA, 1=immediate, 2=input port
- sel_reg_wr  out  1  destination is R0 (LRG)
- ld_pc  out  1  PC load strobe
- sel_jmp  out  1  PC ← jump target
- sel_desv  out  1  PC ← branch target
- in_ready  out  1  ready for input data
- out_valid  out  1  output data is valid

## Operation
- States: FETCH=0, WAIT=1, DECODE=2, EXEC=3, IO=4, PCUPD=5. Codes 6 and 7 go to FETCH with all outputs 0.
- All outputs are registered. The values listed are those seen while estado equals the named state.
- Reset (asynchronous, at any time, including mid-instruction or mid-handshake): estado=FETCH and every output is 0.
- FETCH: all outputs 0. Load wait counter with IMEM_WAIT-1. Go to WAIT.
- WAIT: all outputs 0. Decrement the counter. Go to DECODE when the counter reaches 0.
- DECODE: all outputs 0. Sample op.
  - INPUT and OUTPUT go to IO.
  - NOP and JMP go to PCUPD.
  - All other opcodes go to EXEC.
- EXEC: outputs depend on op. Next state is always PCUPD.
  - ADD/AND/OR/SUB/NEG/NOT: cmd_ula set to the matching code, wr=1.
  - CPY: cmd_ula=TSTR1, wr=1.
  - LRG: wr=1, sel_dt_wr=1, sel_reg_wr=1.
  - BLT/BGT/BEQ/BNE: cmd_ula=SUB, wr=0. The branch condition is registered at the end of EXEC.
    - BEQ: result_ula==0.
    - BNE: result_ula!=0.
    - BLT: result_ula[DATA_W-1]=1 if SIGNED_BR=1; ula_borrow=1 if SIGNED_BR=0.
    - BGT: condition is (not BLT-condition) and result_ula!=0.
  - INPUT (entered from IO): wr=1, sel_dt_wr=2.
- IO, INPUT: in_ready=1. Stay in IO until in_valid=1 is sampled, then go to EXEC.
- IO, OUTPUT: cmd_ula=TSTR1, out_valid=1. Stay in IO until out_ready=1 is sampled, then go to PCUPD. The transfer occurs on that edge.
- PCUPD: ld_pc=1 for exactly one cycle. wr=0. Next state is FETCH.
  - sel_jmp=1 only for JMP.
  - sel_desv equals the registered condition for branch opcodes, else 0.
- wr is never high for more than one consecutive cycle. It is never high outside EXEC.
- in_ready and out_valid are never high outside IO, and never both high at the same time.

## Timing
- Instruction length L = 3 + IMEM_WAIT + k, where k is:
  - 0 for NOP and JMP (FETCH, WAIT×IMEM_WAIT, DECODE, PCUPD);
  - 1 for ALU, CPY, LRG and branch opcodes (adds EXEC).
- INPUT: L = 5 + IMEM_WAIT + n, where n is the number of cycles in IO before in_valid is sampled high (n ≥ 0).
- OUTPUT: L = 4 + IMEM_WAIT + n, where n is the number of cycles in IO before out_ready is sampled high.
- Handshakes have no timeout. A stalled IO state holds indefinitely.
- in_valid=1 while the controller is not in IO is ignored.
- ld_pc rises on the edge that enters PCUPD and falls on the edge that enters FETCH.
- op must be stable from DECODE through PCUPD. result_ula must be stable in the last EXEC cycle.

## Test plan
- Reset then ADD, IMEM_WAIT=1: estado follows 0,1,2,3,5,0. In EXEC, cmd_ula=1 and wr=1. In PCUPD, ld_pc=1 and sel_jmp=sel_desv=0. Total 5 cycles.
- Branches, DATA_W=8, SIGNED_BR=1:
  - BEQ with result_ula=0x00 → sel_desv=1 in PCUPD.
  - BNE with 0x00 → sel_desv=0.
  - BLT with 0x80 → 1.
  - BGT with 0x80 → 0.
  - BGT with 0x05 → 1.
- Repeat BLT with SIGNED_BR=0, result_ula=0x80, ula_borrow=0 → sel_desv=0.
- INPUT, in_valid held low 3 cycles after entering IO: in_ready=1 for 4 cycles, then EXEC with wr=1 and sel_dt_wr=2, then PCUPD.
- OUTPUT with out_ready=1 immediately: out_valid=1 for exactly 1 cycle, cmd_ula=0, then PCUPD with ld_pc=1.
- IMEM_WAIT=4 with a JMP: WAIT lasts 4 cycles, total 7 cycles, sel_jmp=1 in PCUPD. Assert rst low during IO of a stalled OUTPUT → estado=0 and all outputs 0 immediately, and the next instruction proceeds normally.

Source files
------------

// File: rtl/nano_ctrl_mc_if.sv
// Bus between the Nano multicycle controller and its datapath / IO devices.
// The master modport is the controller side; the slave modport is the datapath side.
interface nano_ctrl_mc_if #(
   parameter int DATA_W = 8
);
   logic [3:0]        op;
   logic [DATA_W-1:0] result_ula;
   logic              ula_borrow;
   logic              in_valid;
   logic              out_ready;
   logic [2:0]        estado;
   logic [2:0]        cmd_ula;
   logic              wr;
   logic [1:0]        sel_dt_wr;
   logic              sel_reg_wr;
   logic              ld_pc;
   logic              sel_jmp;
   logic              sel_desv;
   logic              in_ready;
   logic              out_valid;

   modport master (
      input  op, result_ula, ula_borrow, in_valid, out_ready,
      output estado, cmd_ula, wr, sel_dt_wr, sel_reg_wr, ld_pc,
             sel_jmp, sel_desv, in_ready, out_valid
   );

   modport slave (
      output op, result_ula, ula_borrow, in_valid, out_ready,
      input  estado, cmd_ula, wr, sel_dt_wr, sel_reg_wr, ld_pc,
             sel_jmp, sel_desv, in_ready, out_valid
   );
endinterface

// File: rtl/nano_ctrl_mc.sv
// Multicycle control unit for the Nano processor: FETCH, WAIT, DECODE, EXEC/IO, PCUPD.
// Every output is a register loaded with the value belonging to the state being entered.
module nano_ctrl_mc #(
   parameter int DATA_W    = 8,
   parameter int IMEM_WAIT = 1,
   parameter int SIGNED_BR = 1
) (
   input  logic             clk,
   input  logic             rst,
   nano_ctrl_mc_if.master   bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_WAIT   = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_IO     = 3'd4,
      S_PCUPD  = 3'd5
   } state_e;

   localparam logic [3:0] OP_NOP = 4'd0,  OP_ADD = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4,  OP_NEG = 4'd5,  OP_NOT = 4'd6,  OP_CPY = 4'd7;
   localparam logic [3:0] OP_LRG = 4'd8,  OP_JMP = 4'd9,  OP_BEQ = 4'd10, OP_BNE = 4'd11;
   localparam logic [3:0] OP_BLT = 4'd12, OP_BGT = 4'd13, OP_IN  = 4'd14, OP_OUT = 4'd15;

   localparam logic [2:0] CMD_TSTR1 = 3'd0, CMD_ADD = 3'd1, CMD_AND = 3'd2, CMD_OR = 3'd3;
   localparam logic [2:0] CMD_SUB   = 3'd4, CMD_NEG = 3'd5, CMD_NOT = 3'd6;

   localparam logic [3:0] WAIT_LOAD = 4'(IMEM_WAIT - 1);

   // EXEC-state control word {cmd_ula, wr, sel_dt_wr, sel_reg_wr} for opcodes entering from DECODE.
   function automatic logic [6:0] exec_ctl(input logic [3:0] o);
      case (o)
         OP_ADD:  exec_ctl = {CMD_ADD,   1'b1, 2'd0, 1'b0};
         OP_AND:  exec_ctl = {CMD_AND,   1'b1, 2'd0, 1'b0};
         OP_OR:   exec_ctl = {CMD_OR,    1'b1, 2'd0, 1'b0};
         OP_SUB:  exec_ctl = {CMD_SUB,   1'b1, 2'd0, 1'b0};
         OP_NEG:  exec_ctl = {CMD_NEG,   1'b1, 2'd0, 1'b0};
         OP_NOT:  exec_ctl = {CMD_NOT,   1'b1, 2'd0, 1'b0};
         OP_CPY:  exec_ctl = {CMD_TSTR1, 1'b1, 2'd0, 1'b0};
         OP_LRG:  exec_ctl = {CMD_TSTR1, 1'b1, 2'd1, 1'b1};
         OP_BEQ, OP_BNE, OP_BLT, OP_BGT:
                  exec_ctl = {CMD_SUB,   1'b0, 2'd0, 1'b0};
         default: exec_ctl = 7'd0;
      endcase
   endfunction

   state_e     state_q;
   logic [3:0] cnt_q;
   logic [3:0] op_q;
   logic [2:0] cmd_q;
   logic       wr_q;
   logic [1:0] dt_q;
   logic       reg_q;
   logic       ld_q;
   logic       jmp_q;
   logic       desv_q;
   logic       ir_q;
   logic       ov_q;

   logic       zero_s;
   logic       lt_s;
   logic       cond_s;

   assign zero_s = (bus.result_ula == {DATA_W{1'b0}});
   assign lt_s   = (SIGNED_BR != 0) ? bus.result_ula[DATA_W-1] : bus.ula_borrow;

   // Branch condition for the opcode held since DECODE, evaluated on the live ULA result.
   always_comb begin
      cond_s = 1'b0;
      case (op_q)
         OP_BEQ:  cond_s = zero_s;
         OP_BNE:  cond_s = !zero_s;
         OP_BLT:  cond_s = lt_s;
         OP_BGT:  cond_s = !lt_s && !zero_s;
         default: cond_s = 1'b0;
      endcase
   end

   // Sequencer: next state plus the registered outputs that belong to it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
         cnt_q   <= 4'd0;
         op_q    <= 4'd0;
         cmd_q   <= 3'd0;
         wr_q    <= 1'b0;
         dt_q    <= 2'd0;
         reg_q   <= 1'b0;
         ld_q    <= 1'b0;
         jmp_q   <= 1'b0;
         desv_q  <= 1'b0;
         ir_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         cmd_q  <= 3'd0;
         wr_q   <= 1'b0;
         dt_q   <= 2'd0;
         reg_q  <= 1'b0;
         ld_q   <= 1'b0;
         jmp_q  <= 1'b0;
         desv_q <= 1'b0;
         ir_q   <= 1'b0;
         ov_q   <= 1'b0;
         case (state_q)
            S_FETCH: begin
               cnt_q   <= WAIT_LOAD;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= S_DECODE;
               end else begin
                  cnt_q   <= cnt_q - 4'd1;
                  state_q <= S_WAIT;
               end
            end
            S_DECODE: begin
               op_q <= bus.op;
               case (bus.op)
                  OP_IN: begin
                     state_q <= S_IO;
                     ir_q    <= 1'b1;
                  end
                  OP_OUT: begin
                     state_q <= S_IO;
                     ov_q    <= 1'b1;
                     cmd_q   <= CMD_TSTR1;
                  end
                  OP_NOP, OP_JMP: begin
                     state_q <= S_PCUPD;
                     ld_q    <= 1'b1;
                     jmp_q   <= (bus.op == OP_JMP);
                  end
                  default: begin
                     state_q <= S_EXEC;
                     {cmd_q, wr_q, dt_q, reg_q} <= exec_ctl(bus.op);
                  end
               endcase
            end
            S_EXEC: begin
               state_q <= S_PCUPD;
               ld_q    <= 1'b1;
               desv_q  <= cond_s;
            end
            S_IO: begin
               if (op_q == OP_IN) begin
                  if (bus.in_valid) begin
                     state_q <= S_EXEC;
                     wr_q    <= 1'b1;
                     dt_q    <= 2'd2;
                  end else begin
                     state_q <= S_IO;
                     ir_q    <= 1'b1;
                  end
               end else begin
                  if (bus.out_ready) begin
                     state_q <= S_PCUPD;
                     ld_q    <= 1'b1;
                  end else begin
                     state_q <= S_IO;
                     ov_q    <= 1'b1;
                  end
               end
            end
            S_PCUPD: begin
               state_q <= S_FETCH;
            end
            default: begin
               state_q <= S_FETCH;
            end
         endcase
      end
   end

   assign bus.estado     = state_q;
   assign bus.cmd_ula    = cmd_q;
   assign bus.wr         = wr_q;
   assign bus.sel_dt_wr  = dt_q;
   assign bus.sel_reg_wr = reg_q;
   assign bus.ld_pc      = ld_q;
   assign bus.sel_jmp    = jmp_q;
   assign bus.sel_desv   = desv_q;
   assign bus.in_ready   = ir_q;
   assign bus.out_valid  = ov_q;
endmodule
